// File: rtl/snn_pkg.sv
// Shared spiking-network types and default sizes for the AER event path.
package snn_pkg;

    localparam int DEF_N_NEURONS  = 8;
    localparam int DEF_TS_WIDTH   = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    // A single neuron still needs a 1-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ID_WIDTH = id_width(DEF_N_NEURONS);

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0] id;
        logic [DEF_TS_WIDTH-1:0] ts;
    } aer_event_t;

endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous event FIFO with registered full/empty and occupancy count.
// Latency: push visible at head one cycle later; push ignored when full, pop ignored when empty.
module spike_event_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Turns per-neuron spike pulses into timestamped AER events, lowest index first.
// Latency: 2 cycles spike -> aer_valid; aer_ready low holds the head, full FIFO stalls draining and re-spikes count as drops.
module spike_aer_encoder
    import snn_pkg::*;
#(
    parameter int N_NEURONS  = DEF_N_NEURONS,
    parameter int TS_WIDTH   = DEF_TS_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_NEURONS-1:0]           spike_in,
    output logic                           aer_valid,
    input  logic                           aer_ready,
    output logic [id_width(N_NEURONS)-1:0] aer_id,
    output logic [TS_WIDTH-1:0]            aer_ts,
    output logic [7:0]                     drop_count
);
    localparam int ID_W = id_width(N_NEURONS);
    localparam int EV_W = ID_W + TS_WIDTH;

    logic [TS_WIDTH-1:0]  ts;
    logic [N_NEURONS-1:0] pending;
    logic [N_NEURONS-1:0] pending_nxt;
    logic [TS_WIDTH-1:0]  ts_latch [N_NEURONS];
    logic [N_NEURONS-1:0] drain_oh;
    logic [N_NEURONS-1:0] drop_vec;
    logic [ID_W-1:0]      drain_id;
    logic                 drain;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [EV_W-1:0]      push_dat;
    logic [EV_W-1:0]      head_dat;
    logic [31:0]          drop_sum;
    logic [7:0]           drop_nxt;

    // Only registered pending bits compete, so a spike is never drained in its own cycle.
    always_comb begin
        drain_id = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                drain_id = ID_W'(i);
            end
        end
        drain    = (|pending) && !fifo_full;
        drain_oh = drain ? (N_NEURONS'(1) << drain_id) : '0;
        push_dat = {drain_id, ts_latch[drain_id]};
    end

    always_comb begin
        pending_nxt = pending & ~drain_oh;
        drop_vec    = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (spike_in[i]) begin
                if (pending[i] && !drain_oh[i]) begin
                    drop_vec[i] = 1'b1;
                end else begin
                    pending_nxt[i] = 1'b1;
                end
            end
        end
        drop_sum = 32'(drop_count) + 32'($countones(drop_vec));
        drop_nxt = (drop_sum > 32'd255) ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts         <= '0;
            pending    <= '0;
            drop_count <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                ts_latch[i] <= '0;
            end
        end else begin
            ts         <= ts + TS_WIDTH'(1);
            pending    <= pending_nxt;
            drop_count <= drop_nxt;
            for (int i = 0; i < N_NEURONS; i++) begin
                if (spike_in[i] && !drop_vec[i]) begin
                    ts_latch[i] <= ts;
                end
            end
        end
    end

    spike_event_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (drain),
        .push_dat (push_dat),
        .pop      (aer_ready),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign aer_valid        = !fifo_empty;
    assign {aer_id, aer_ts} = head_dat;

endmodule

// File: doc/spike_aer_encoder.md
SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 SHALL have parameter N_NEURONS, default 8: number of LIF neuron spike inputs.
REQ-002 SHALL have parameter TS_WIDTH, default 8: timestamp width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: event FIFO entries (power of two).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port spike_in, input, N_NEURONS: bit i is the spike output of neuron i, one-cycle pulses.
REQ-007 SHALL have port aer_valid, output, 1: event available.
REQ-008 SHALL have port aer_ready, input, 1: consumer accepts event.
REQ-009 SHALL have port aer_id, output, clog2(N_NEURONS): neuron index of event.
REQ-010 SHALL have port aer_ts, output, TS_WIDTH: timestamp of event.
REQ-011 SHALL have port drop_count, output, 8: count of lost spikes, saturating.

Function
REQ-012 SHALL keep a free-running ts counter: +1 per cycle, wraps 2^TS_WIDTH-1 -> 0.
REQ-013 SHALL, for spike_in[i]=1 with pending[i]=0, set pending[i] and latch ts_latch[i] = ts of that cycle (pre-increment).
REQ-014 SHALL, for spike_in[i]=1 with pending[i]=1 and i not drained that cycle, keep ts_latch[i] unchanged and increment drop_count (saturating at 255).
REQ-015 SHALL, for spike_in[i]=1 in the cycle i is drained, keep pending[i]=1 with new ts_latch[i]; no drop.
REQ-016 SHALL drain at most one pending bit per cycle, only when FIFO not full: lowest pending index wins, pending bit cleared, {i, ts_latch[i]} pushed.
REQ-017 SHALL not drain a pending bit in the same cycle it is set; minimum latency spike_in -> aer_valid = 2 cycles.
REQ-018 SHALL assert aer_valid iff FIFO non-empty; aer_id/aer_ts show FIFO head.
REQ-019 SHALL pop on aer_valid && aer_ready; hold aer_id/aer_ts stable while aer_valid && !aer_ready.
REQ-020 SHALL base push eligibility on registered full: when full, no push even if a pop occurs that cycle.
REQ-021 SHALL support push and pop in the same cycle when not full/not empty, occupancy unchanged.
REQ-022 SHALL preserve event order: FIFO first-in first-out; neurons spiking in the same cycle emerge in ascending index.

Reset
REQ-023 SHALL on rst=1 clear ts, pending, ts_latch, FIFO pointers/occupancy, drop_count; aer_valid=0 the cycle after.
REQ-024 SHALL discard all queued and pending events on reset mid-operation; spike_in ignored while rst=1.

Structure
REQ-025 SHALL take N_NEURONS, TS_WIDTH defaults and aer_event_t struct {id, ts} from shared package snn_pkg.
REQ-026 SHALL implement the FIFO as sub-module spike_event_fifo (sync, registered full/empty, count).

Verification
REQ-027 SHALL cover: reset, aer_ready=1, spike_in[3] at ts=5 -> one beat 2 cycles later, aer_id=3, aer_ts=5.
REQ-028 SHALL cover: spikes on neurons 0,2,7 in one cycle at ts=10, aer_ready=1 -> beats id 0,2,7 on consecutive cycles, all ts=10.
REQ-029 SHALL cover: aer_ready=0, all 8 neurons spike once -> FIFO holds ids 0-3, head id0 stable; then aer_ready=1 -> ids 0..7 in order, drop_count=0.
REQ-030 SHALL cover: FIFO full, neuron 5 pending, neuron 5 spikes again -> drop_count=1, later event for 5 carries first ts.
REQ-031 SHALL cover: spikes at ts=255 and ts=0 (wrap) -> events carry aer_ts=255 then 0.
REQ-032 SHALL cover: rst pulsed one cycle with 3 events queued -> aer_valid=0, drop_count=0, ts restarts at 0, no stale events afterward.
